// File: rtl/sysclk_frac_divider_pkg.sv
// Shared definitions for the fractional clock divider: channel FSM states,
// the minimum legal integer period and the channel-select width helper.
package sysclk_frac_divider_pkg;

  // Shortest period a channel can produce (one high cycle, one low cycle).
  localparam int unsigned DIV_MIN = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

  // Width of the channel-select field; at least one bit even for one channel.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sysclk_frac_divider_chan.sv
// One divider channel: period counter, fractional accumulator, shadow/active
// divisor pair and registered clk_out/tick outputs.
// Ports:
//   clk, rst_n  fabric clock, async active-low reset
//   en_i        run enable
//   wr_i        accepted divisor write for this channel
//   div_i       divisor {integer, fraction}
//   clk_out_o   divided clock (flop)
//   tick_o      last-cycle-of-period pulse (flop)
//   busy_o      shadow divisor waiting to be applied (flop)
module sysclk_frac_divider_chan
  import sysclk_frac_divider_pkg::*;
#(
  parameter int unsigned INT_W   = 12,
  parameter int unsigned FRAC_W  = 8,
  parameter int unsigned DEF_DIV = 256 << 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    wr_i,
  input  logic [INT_W+FRAC_W-1:0] div_i,
  output logic                    clk_out_o,
  output logic                    tick_o,
  output logic                    busy_o
);

  localparam int unsigned DW = INT_W + FRAC_W;
  localparam int unsigned PW = INT_W + 1;
  localparam int unsigned HW = PW + 1;
  localparam int unsigned AW = (FRAC_W > 0) ? FRAC_W : 1;

  // Integer part of a divisor, clamped to the shortest legal period.
  function automatic logic [PW-1:0] ieff(input logic [DW-1:0] div);
    logic [PW-1:0] ipart;
    ipart = PW'(div[DW-1:FRAC_W]);
    return (ipart < PW'(DIV_MIN)) ? PW'(DIV_MIN) : ipart;
  endfunction

  chan_state_e   state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] per_q, per_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [DW-1:0] active_q, active_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          clk_out_q, clk_out_d;
  logic          tick_q, tick_d;

  logic [AW-1:0] act_frac;
  logic [AW:0]   acc_sum;
  logic [HW-1:0] half_d;
  logic          last_c;

  // Fraction field of the active divisor; zero when there are no fraction bits.
  if (FRAC_W > 0) begin : g_frac
    assign act_frac = active_q[AW-1:0];
  end else begin : g_nofrac
    assign act_frac = '0;
  end

  assign acc_sum = {1'b0, acc_q} + {1'b0, act_frac};
  assign last_c  = (cnt_q == per_q - PW'(1));

  // Next-state: period counting, boundary reload and divisor hand-over.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    acc_d     = acc_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        acc_d = '0;
        // A shadow written while idle is applied on the very next edge.
        if (pending_q) begin
          active_d  = shadow_q;
          pending_d = 1'b0;
        end
        if (en_i) begin
          state_d = ST_RUN;
          per_d   = ieff(pending_q ? shadow_q : active_q);
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          acc_d   = '0;
          if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
          end
        end else if (last_c) begin
          cnt_d = '0;
          if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
            acc_d     = '0;
            per_d     = ieff(shadow_q);
          end else begin
            // Fraction overflow stretches the next period by one cycle.
            acc_d = acc_sum[AW-1:0];
            per_d = ieff(active_q) + PW'(acc_sum[AW]);
          end
        end else begin
          cnt_d = cnt_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Writes are only accepted with pending clear, so this never collides with an apply.
    if (wr_i) begin
      shadow_d  = div_i;
      pending_d = 1'b1;
    end
  end

  // Outputs are precomputed from next state so they come straight off flops.
  assign half_d    = ({1'b0, per_d} + HW'(1)) >> 1;
  assign clk_out_d = (state_d == ST_RUN) && ({1'b0, cnt_d} < half_d);
  assign tick_d    = (state_d == ST_RUN) && (cnt_d == per_d - PW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      per_q     <= ieff(DW'(DEF_DIV));
      acc_q     <= '0;
      active_q  <= DW'(DEF_DIV);
      shadow_q  <= '0;
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      acc_q     <= acc_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;
  assign busy_o    = pending_q;

endmodule

// File: rtl/sysclk_frac_divider.sv
// Multi-channel fractional clock divider. Decodes the divisor-write channel,
// muxes the write-ready flag and gathers per-channel outputs.
// Ports:
//   clk, rst_n  fabric clock, async active-low reset
//   en          per-channel run enable
//   cfg_valid   divisor write request; cfg_ready = !busy[cfg_chan] (1 if out of range)
//   cfg_chan    target channel
//   cfg_div     divisor {integer, fraction}
//   clk_out     divided clocks
//   tick        one-cycle pulse in the last cycle of each period
//   busy        shadow divisor loaded but not yet applied
module sysclk_frac_divider
  import sysclk_frac_divider_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 2,
  parameter  int unsigned INT_W   = 12,
  parameter  int unsigned FRAC_W  = 8,
  parameter  int unsigned DEF_DIV = 256 << FRAC_W,
  localparam int unsigned CH_W    = ch_width(NUM_CH),
  localparam int unsigned DW      = INT_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_chan,
  input  logic [DW-1:0]     cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  logic              chan_ok_c;
  logic [NUM_CH-1:0] wr_c;

  assign chan_ok_c = (32'(cfg_chan) < NUM_CH);

  // Writes to a non-existent channel are always ready and simply dropped.
  always_comb begin
    cfg_ready = 1'b1;
    if (chan_ok_c) cfg_ready = !busy[cfg_chan];
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr_c[c] = cfg_valid && cfg_ready && (32'(cfg_chan) == 32'(c));

    sysclk_frac_divider_chan #(
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (en[c]),
      .wr_i     (wr_c[c]),
      .div_i    (cfg_div),
      .clk_out_o(clk_out[c]),
      .tick_o   (tick[c]),
      .busy_o   (busy[c])
    );
  end

endmodule

// File: tb/tb_sysclk_frac_divider.sv
module tb_sysclk_frac_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [0:0]  cfg_chan;
  logic [19:0] cfg_div;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
  logic [1:0]  busy;

  int n_pass = 0;
  int n_total = 0;

  sysclk_frac_divider dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: position inside the current period plus the period index
  // since the divisor was (re)loaded; period length follows from floor arithmetic.
  bit          m_run [2];
  int          m_pos [2];
  int          m_plen[2];
  int          m_k   [2];
  logic [19:0] m_act [2];
  logic [19:0] m_sh  [2];
  bit          m_pend[2];

  function automatic int plen_of(input logic [19:0] d, input int k);
    longint ip, fp, base;
    ip   = longint'(d[19:8]);
    fp   = longint'(d[7:0]);
    base = (ip < 2) ? 2 : ip;
    if (k == 0) return int'(base);
    return int'(base + ((longint'(k) * fp) / 256) - ((longint'(k - 1) * fp) / 256));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_run[c] = 0; m_pos[c] = 0; m_plen[c] = 256; m_k[c] = 0;
      m_act[c] = 20'h10000; m_sh[c] = '0; m_pend[c] = 0;
    end
  endtask

  task automatic model_step();
    bit rdy;
    bit wr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rdy = !m_pend[cfg_chan];
    for (int c = 0; c < 2; c++) begin
      wr = cfg_valid && rdy && (int'(cfg_chan) == c);
      if (!m_run[c]) begin
        if (m_pend[c]) begin m_act[c] = m_sh[c]; m_pend[c] = 0; end
        if (en[c]) begin
          m_run[c] = 1; m_k[c] = 0; m_pos[c] = 0;
          m_plen[c] = plen_of(m_act[c], 0);
        end
      end else if (!en[c]) begin
        m_run[c] = 0; m_pos[c] = 0;
        if (m_pend[c]) begin m_act[c] = m_sh[c]; m_pend[c] = 0; end
      end else if (m_pos[c] == m_plen[c] - 1) begin
        if (m_pend[c]) begin
          m_act[c] = m_sh[c]; m_pend[c] = 0; m_k[c] = 0;
        end else begin
          m_k[c]++;
        end
        m_pos[c] = 0;
        m_plen[c] = plen_of(m_act[c], m_k[c]);
      end else begin
        m_pos[c]++;
      end
      if (wr) begin m_sh[c] = cfg_div; m_pend[c] = 1; end
    end
  endtask

  // Expected {clk_out, tick, busy, cfg_ready} for the cycle after the last edge.
  function automatic logic [6:0] exp_vec();
    logic [1:0] ck, tk, bz;
    for (int c = 0; c < 2; c++) begin
      ck[c] = m_run[c] && (m_pos[c] < (m_plen[c] + 1) / 2);
      tk[c] = m_run[c] && (m_pos[c] == m_plen[c] - 1);
      bz[c] = m_pend[c];
    end
    return {ck, tk, bz, !m_pend[cfg_chan]};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {clk_out, tick, busy, cfg_ready};
  endfunction

  // Advance one clock: model follows the edge, then wait to the sampling edge.
  task automatic tick_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic write_div(input logic ch, input logic [19:0] d);
    cfg_chan = ch; cfg_div = d; cfg_valid = 1'b1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst_n = 1'b0; en = '0; cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0;
    model_reset();
    repeat (3) @(negedge clk);
    got = dut_vec();
    n_total++;
    if (got !== 7'b0000001) $display("FAIL reset_state got %b exp %b", got, 7'b0000001);
    else n_pass++;
    rst_n = 1'b1;
    repeat (4) begin
      tick_cycle();
      got = dut_vec(); n_total++;
      if (got !== exp_vec()) $display("FAIL reset_idle got %b exp %b", got, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_default();
    logic [6:0] got;
    int highs, ticks, tick_at;
    highs = 0; ticks = 0; tick_at = -1;
    en = 2'b01;
    for (int i = 0; i < 600; i++) begin
      tick_cycle();
      got = dut_vec(); n_total++;
      if (got !== exp_vec()) $display("FAIL default cyc %0d got %b exp %b", i, got, exp_vec());
      else n_pass++;
      if (i < 256) begin
        highs += int'(clk_out[0]);
        ticks += int'(tick[0]);
        if (tick[0] === 1'b1) tick_at = i;
      end
    end
    n_total++;
    if (highs !== 128 || ticks !== 1 || tick_at !== 255)
      $display("FAIL default_shape highs %0d ticks %0d at %0d exp 128 1 255", highs, ticks, tick_at);
    else n_pass++;
    en = 2'b00;
    tick_cycle();
  endtask

  task automatic test_int5();
    logic [6:0] got;
    logic [4:0] ck, tk;
    write_div(1'b1, 20'h00500);
    tick_cycle();
    cfg_valid = 1'b0;
    n_total++;
    if (busy !== 2'b10) $display("FAIL int5_busy got %b exp 10", busy);
    else n_pass++;
    tick_cycle();
    en = 2'b10;
    for (int i = 0; i < 40; i++) begin
      tick_cycle();
      got = dut_vec(); n_total++;
      if (got !== exp_vec()) $display("FAIL int5 cyc %0d got %b exp %b", i, got, exp_vec());
      else n_pass++;
      if (i < 5) begin ck[4 - i] = clk_out[1]; tk[4 - i] = tick[1]; end
    end
    n_total++;
    if (ck !== 5'b11100 || tk !== 5'b00001)
      $display("FAIL int5_shape clk %b tick %b exp 11100 00001", ck, tk);
    else n_pass++;
  endtask

  task automatic test_frac();
    logic [6:0] got;
    int ticks;
    ticks = 0;
    en = 2'b00;
    tick_cycle();
    write_div(1'b1, 20'h00380);
    tick_cycle();
    cfg_valid = 1'b0;
    tick_cycle();
    en = 2'b10;
    for (int i = 0; i < 3500; i++) begin
      tick_cycle();
      got = dut_vec(); n_total++;
      if (got !== exp_vec()) $display("FAIL frac cyc %0d got %b exp %b", i, got, exp_vec());
      else n_pass++;
      ticks += int'(tick[1]);
    end
    n_total++;
    if (ticks !== 1000) $display("FAIL frac_mean ticks %0d exp 1000", ticks);
    else n_pass++;
  endtask

  task automatic test_midwrite();
    logic [6:0] got;
    int n, guard;
    en = 2'b00;
    tick_cycle();
    en = 2'b01;
    guard = 0;
    do begin
      tick_cycle(); guard++;
    end while (m_pos[0] != 50 && guard < 400);
    n_total++;
    if (m_pos[0] != 50 || tick[0] !== 1'b0) $display("FAIL midwrite_reach pos %0d exp 50", m_pos[0]);
    else n_pass++;
    write_div(1'b0, 20'h00A00);
    tick_cycle();
    n_total++;
    if (busy[0] !== 1'b1 || cfg_ready !== 1'b0)
      $display("FAIL midwrite_stall busy %b ready %b exp 1 0", busy[0], cfg_ready);
    else n_pass++;
    // A second write is held against the stall; it must not be taken.
    write_div(1'b0, 20'h01400);
    n = 1;
    for (int i = 0; i < 300 && tick[0] !== 1'b1; i++) begin
      if (n == 100) cfg_valid = 1'b0;
      tick_cycle(); n++;
      got = dut_vec(); n_total++;
      if (got !== exp_vec()) $display("FAIL midwrite cyc %0d got %b exp %b", i, got, exp_vec());
      else n_pass++;
    end
    cfg_valid = 1'b0;
    n_total++;
    if (n !== 205) $display("FAIL midwrite_old_period samples %0d exp 205", n);
    else n_pass++;
    n = 0;
    do begin
      tick_cycle(); n++;
    end while (tick[0] !== 1'b1 && n < 300);
    n_total++;
    if (n !== 10 || busy[0] !== 1'b0) $display("FAIL midwrite_new_period len %0d busy %b exp 10 0", n, busy[0]);
    else n_pass++;
  endtask

  task automatic test_small(input logic [19:0] d);
    logic [6:0] got;
    int highs, ticks;
    highs = 0; ticks = 0;
    en = 2'b00;
    tick_cycle();
    write_div(1'b1, d);
    tick_cycle();
    cfg_valid = 1'b0;
    tick_cycle();
    en = 2'b10;
    for (int i = 0; i < 8; i++) begin
      tick_cycle();
      got = dut_vec(); n_total++;
      if (got !== exp_vec()) $display("FAIL small_%05h cyc %0d got %b exp %b", d, i, got, exp_vec());
      else n_pass++;
      highs += int'(clk_out[1]);
      ticks += int'(tick[1]);
    end
    n_total++;
    if (highs !== 4 || ticks !== 4) $display("FAIL small_%05h_shape highs %0d ticks %0d exp 4 4", d, highs, ticks);
    else n_pass++;
  endtask

  task automatic test_boundary_write();
    logic [5:0] seq;
    int guard;
    guard = 0;
    while (m_pos[1] != 1 && guard < 10) begin tick_cycle(); guard++; end
    write_div(1'b1, 20'h00400);
    tick_cycle();
    cfg_valid = 1'b0;
    n_total++;
    if (busy[1] !== 1'b1) $display("FAIL bwrite_pending busy %b exp 1", busy[1]);
    else n_pass++;
    seq[5] = tick[1];
    for (int i = 4; i >= 0; i--) begin tick_cycle(); seq[i] = tick[1]; end
    n_total++;
    if (seq !== 6'b010001) $display("FAIL bwrite_defer ticks %b exp 010001", seq);
    else n_pass++;
  endtask

  task automatic test_drop_and_reset();
    logic [6:0] got;
    int guard;
    en = 2'b01;
    guard = 0;
    do begin tick_cycle(); guard++; end while (m_pos[0] != 7 && guard < 40);
    en = 2'b00;
    tick_cycle();
    n_total++;
    if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) $display("FAIL endrop clk %b tick %b exp 0 0", clk_out[0], tick[0]);
    else n_pass++;
    en = 2'b01;
    tick_cycle();
    n_total++;
    if (clk_out[0] !== 1'b1 || tick[0] !== 1'b0) $display("FAIL reenable clk %b tick %b exp 1 0", clk_out[0], tick[0]);
    else n_pass++;
    en = 2'b11;
    repeat (5) tick_cycle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    got = dut_vec(); n_total++;
    if (got !== 7'b0000001) $display("FAIL async_reset got %b exp %b", got, 7'b0000001);
    else n_pass++;
    @(negedge clk);
    en = 2'b00;
    rst_n = 1'b1;
    tick_cycle();
    en = 2'b01;
    tick_cycle();
    got = dut_vec(); n_total++;
    if (got !== exp_vec() || m_plen[0] != 256) $display("FAIL post_reset got %b exp %b", got, exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] got;
    logic [19:0] d;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) en[0] = ~en[0];
      if ($urandom_range(0, 63) == 0) en[1] = ~en[1];
      d = {8'h00, 4'($urandom_range(0, 12)), 8'($urandom)};
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_chan  = 1'($urandom);
      cfg_div   = d;
      tick_cycle();
      got = dut_vec(); n_total++;
      if (got !== exp_vec()) $display("FAIL random cyc %0d got %b exp %b", i, got, exp_vec());
      else n_pass++;
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default();
    test_int5();
    test_frac();
    test_midwrite();
    test_small(20'h00000);
    test_small(20'h00100);
    test_boundary_write();
    test_drop_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
